// File: rtl/seq_multiplier.sv
// seq_multiplier: iterative shift-and-add multiplier, one multiplier bit per clock,
// with optional two's-complement mode via magnitude multiply and final sign fix.
module seq_multiplier #(
  parameter int WIDTH  = 16,
  parameter bit SIGNED = 1'b0
) (
  input  logic               CLK,
  input  logic               RESET,
  input  logic               START,
  input  logic               CLEAR,
  input  logic [WIDTH-1:0]   OP_A,
  input  logic [WIDTH-1:0]   OP_B,
  output logic [2*WIDTH-1:0] PRODUCT,
  output logic               BUSY,
  output logic               done
);
  localparam int CW = WIDTH > 1 ? $clog2(WIDTH) : 1;
  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;
  state_t               state_q, state_d;
  logic [2*WIDTH-1:0]   acc_q, acc_d, prod_q, prod_d, addend, acc_sum;
  logic [WIDTH-1:0]     ma_q, ma_d, mb_q, mb_d, mag_a, mag_b;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic                 neg_q, neg_d, busy_q, busy_d, done_q, done_d;
  assign PRODUCT = prod_q;
  assign BUSY    = busy_q;
  assign done    = done_q;
  // Most-negative operand negates to itself, which read as unsigned is exactly 2^(WIDTH-1).
  assign mag_a   = (SIGNED && OP_A[WIDTH-1]) ? -OP_A : OP_A;
  assign mag_b   = (SIGNED && OP_B[WIDTH-1]) ? -OP_B : OP_B;
  assign addend  = {{WIDTH{1'b0}}, ma_q} << cnt_q;
  assign acc_sum = acc_q + (mb_q[0] ? addend : '0);
  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    prod_d  = prod_q;
    ma_d    = ma_q;
    mb_d    = mb_q;
    cnt_d   = cnt_q;
    neg_d   = neg_q;
    if (CLEAR) begin
      state_d = S_IDLE;
    end else if (state_q != S_RUN && START) begin
      state_d = S_RUN;
      ma_d    = mag_a;
      mb_d    = mag_b;
      neg_d   = SIGNED && (OP_A[WIDTH-1] ^ OP_B[WIDTH-1]);
      acc_d   = '0;
      cnt_d   = '0;
    end else if (state_q == S_RUN) begin
      acc_d = acc_sum;
      mb_d  = mb_q >> 1;
      cnt_d = cnt_q + CW'(1);
      if (cnt_q == CW'(WIDTH - 1)) begin
        state_d = S_DONE;
        prod_d  = neg_q ? -acc_sum : acc_sum;
      end
    end
    busy_d = state_d == S_RUN;
    done_d = state_d == S_DONE;
  end
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state_q <= S_IDLE;
      acc_q   <= '0;
      prod_q  <= '0;
      ma_q    <= '0;
      mb_q    <= '0;
      cnt_q   <= '0;
      neg_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      prod_q  <= prod_d;
      ma_q    <= ma_d;
      mb_q    <= mb_d;
      cnt_q   <= cnt_d;
      neg_q   <= neg_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end
endmodule
